// File: rtl/hub75_bcm_ctl.sv
// hub75_bcm_ctl: HUB75 panel scan controller with binary-coded modulation
module hub75_bcm_ctl #(
  parameter int COLOR_COUNT = 3,
  parameter int COLOR_BITS = 4,
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int SECTIONS = 2,
  parameter int BLANK_CYCLES = 4,
  parameter int ON_UNIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [7:0] brightness,
  input  logic [SECTIONS*COLOR_COUNT*(2**COL_ADDR_BITS)*COLOR_BITS-1:0] row_in,
  input  logic row_valid,
  output logic row_req,
  output logic [ROW_ADDR_BITS-1:0] next_row,
  output logic hub_clk,
  output logic hub_lat,
  output logic hub_noe,
  output logic [ROW_ADDR_BITS-1:0] hub_mux,
  output logic [SECTIONS*COLOR_COUNT-1:0] s_out,
  output logic frame_done
);
  localparam int C = 2**COL_ADDR_BITS;
  localparam int SC = SECTIONS*COLOR_COUNT;
  localparam int BW = SC*C*COLOR_BITS;
  localparam int WMAX = ON_UNIT << (COLOR_BITS-1);
  localparam int M2 = WMAX > 2*C ? WMAX : 2*C;
  localparam int CMAX = M2 > BLANK_CYCLES ? M2 : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX+1);
  localparam int PW = COLOR_BITS > 1 ? $clog2(COLOR_BITS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK_PRE, LATCH, BLANK_POST, DISPLAY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, n_on, n_on_n, win, lim;
  logic [CW+8:0] prod;
  logic [PW-1:0] plane, plane_n;
  logic [ROW_ADDR_BITS-1:0] row_n;
  logic [BW-1:0] pix, pix_n;
  logic [SC-1:0] s_n;
  logic [COL_ADDR_BITS-1:0] col;
  logic fin, done_n;
  always_comb begin
    win = CW'(ON_UNIT << plane);
    prod = (CW+9)'(win) * (CW+9)'({1'b0, brightness} + 9'd1);
    lim = state == SHIFT ? CW'(2*C) : state == DISPLAY ? win : state == LATCH ? CW'(1) : CW'(BLANK_CYCLES);
    fin = cnt == lim - 1'b1;
    state_n = state;
    cnt_n = fin ? '0 : cnt + 1'b1;
    plane_n = plane;
    row_n = next_row;
    pix_n = pix;
    n_on_n = n_on;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = enable ? FETCH : IDLE;
      end
      FETCH: begin
        cnt_n = '0;
        if (row_valid) begin
          state_n = SHIFT;
          pix_n = row_in;
          plane_n = '0;
        end
      end
      SHIFT: state_n = fin ? BLANK_PRE : SHIFT;
      BLANK_PRE: state_n = fin ? LATCH : BLANK_PRE;
      LATCH: state_n = fin ? BLANK_POST : LATCH;
      BLANK_POST: if (fin) begin
        state_n = DISPLAY;
        n_on_n = CW'(prod >> 8);
      end
      DISPLAY: if (fin) begin
        if (plane != PW'(COLOR_BITS-1)) begin
          plane_n = plane + 1'b1;
          state_n = SHIFT;
        end else begin
          row_n = next_row + 1'b1;
          state_n = enable ? FETCH : IDLE;
          done_n = &next_row;
        end
      end
      default: state_n = IDLE;
    endcase
    col = ~cnt_n[COL_ADDR_BITS:1];
    s_n = '0;
    for (int i = 0; i < SC; i++)
      s_n[i] = (state_n == SHIFT) & 1'(pix_n >> ((i*C + int'(col))*COLOR_BITS + int'(plane_n)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      plane <= '0;
      next_row <= '0;
      pix <= '0;
      n_on <= '0;
      hub_clk <= 1'b0;
      hub_lat <= 1'b0;
      hub_noe <= 1'b1;
      hub_mux <= '0;
      s_out <= '0;
      row_req <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      plane <= plane_n;
      next_row <= row_n;
      pix <= pix_n;
      n_on <= n_on_n;
      hub_clk <= state_n == SHIFT && cnt_n[0];
      hub_lat <= state_n == LATCH;
      hub_noe <= !(state_n == DISPLAY && cnt_n < n_on_n);
      hub_mux <= state_n == LATCH ? next_row : hub_mux;
      s_out <= s_n;
      row_req <= state_n == FETCH;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_hub75_bcm_ctl.sv
// tb_hub75_bcm_ctl: table-driven and randomized check of hub75_bcm_ctl against a scan model
module tb_hub75_bcm_ctl;
  localparam int C = 64;
  localparam int CB = 4;
  localparam int RB = 4;
  localparam int SC = 6;
  localparam int BL = 4;
  localparam int ON = 8;
  localparam int BW = SC*C*CB;
  localparam int OW = 3 + RB + SC + 2 + RB;
  localparam logic [OW-1:0] ALL = '1;
  localparam logic [OW-1:0] SM = ~(OW'((1 << SC) - 1) << (RB + 2));
  typedef struct packed {
    logic [3:0] dly;
    logic [7:0] bri;
    logic pat;
    logic [3:0] req;
    logic [3:0][7:0] on;
  } vec_t;
  logic clk = 1'b0;
  logic rst, enable, row_valid;
  logic [7:0] brightness;
  logic [BW-1:0] row_in;
  logic row_req, hub_clk, hub_lat, hub_noe, frame_done;
  logic [RB-1:0] next_row, hub_mux;
  logic [SC-1:0] s_out;
  int nv = 0;
  int nerr = 0;
  logic [RB-1:0] exp_mux;
  vec_t tbl [5];
  hub75_bcm_ctl dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .row_in(row_in), .row_valid(row_valid), .row_req(row_req), .next_row(next_row),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_noe(hub_noe), .hub_mux(hub_mux),
    .s_out(s_out), .frame_done(frame_done)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [OW-1:0] obs();
    return {hub_clk, hub_lat, hub_noe, hub_mux, s_out, frame_done, row_req, next_row};
  endfunction
  function automatic logic [OW-1:0] ev(logic c, logic l, logic n, logic [RB-1:0] m,
                                       logic [SC-1:0] s, logic f, logic q, logic [RB-1:0] r);
    return {c, l, n, m, s, f, q, r};
  endfunction
  function automatic logic [SC-1:0] pixv(logic [BW-1:0] d, int p, int col);
    logic [SC-1:0] r;
    for (int k = 0; k < SC; k++) r[k] = 1'(d >> (((k*C) + col)*CB + p));
    return r;
  endfunction
  function automatic logic [BW-1:0] rnd_row();
    logic [BW-1:0] r;
    for (int i = 0; i < BW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [BW-1:0] pat_row();
    logic [BW-1:0] r = '0;
    for (int col = 0; col < C; col++) begin
      r[col*CB + 1] = 1'b1;
      r[col*CB + 3] = 1'b1;
    end
    return r;
  endfunction
  task automatic check(input string nm, input logic [OW-1:0] e, input logic [OW-1:0] m);
    logic [OW-1:0] g;
    g = obs();
    nv++;
    if ((g & m) !== (e & m)) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h expected=%h mask=%h", nm, $time, g, e, m);
    end
  endtask
  task automatic check_int(input string nm, input int g, input int e);
    nv++;
    if (g != e) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, g, e);
    end
  endtask
  task automatic fetch(input int row, input int dly, input logic [BW-1:0] d, input logic fd, input int req_exp);
    int g, cnt;
    row_valid = 1'b0;
    row_in = d;
    g = 0;
    while (!row_req && g < 50) begin
      @(negedge clk);
      g++;
    end
    cnt = 0;
    while (row_req && cnt < 40) begin
      check("fetch", ev(0, 0, 1, exp_mux, 0, (cnt == 0 && g == 0) ? fd : 1'b0, 1, RB'(row)), SM);
      if (cnt == dly) row_valid = 1'b1;
      cnt++;
      @(negedge clk);
      row_valid = 1'b0;
    end
    check_int("row_req_cycles", cnt, req_exp);
  endtask
  task automatic run_row(input int row, input logic [BW-1:0] d, input logic [7:0] bri,
                         input logic chk_on, input logic [3:0][7:0] on);
    int w, n, low;
    row_in = ~d;
    for (int p = 0; p < CB; p++) begin
      brightness = bri;
      for (int k = 0; k < 2*C; k++) begin
        check("shift", ev(k[0], 0, 1, exp_mux, pixv(d, p, C-1-k/2), 0, 0, RB'(row)), ALL);
        row_valid = 1'($urandom);
        @(negedge clk);
      end
      row_valid = 1'b0;
      for (int k = 0; k < BL; k++) begin
        check("blank_pre", ev(0, 0, 1, exp_mux, 0, 0, 0, RB'(row)), SM);
        @(negedge clk);
      end
      exp_mux = RB'(row);
      check("latch", ev(0, 1, 1, exp_mux, 0, 0, 0, RB'(row)), SM);
      @(negedge clk);
      for (int k = 0; k < BL; k++) begin
        check("blank_post", ev(0, 0, 1, exp_mux, 0, 0, 0, RB'(row)), SM);
        @(negedge clk);
      end
      w = ON << p;
      n = (w * (int'(bri) + 1)) >> 8;
      low = 0;
      for (int i = 0; i < w; i++) begin
        check("display", ev(0, 0, i >= n, exp_mux, 0, 0, 0, RB'(row)), SM);
        if (!hub_noe) low++;
        brightness = 8'($urandom);
        row_valid = 1'($urandom);
        @(negedge clk);
      end
      row_valid = 1'b0;
      if (chk_on) check_int("noe_low_count", low, int'(on[p]));
    end
  endtask
  initial begin
    logic [BW-1:0] d;
    int g, dl;
    rst = 1'b1;
    enable = 1'b0;
    brightness = 8'd0;
    row_valid = 1'b0;
    row_in = '0;
    exp_mux = '0;
    tbl[0] = {4'd3, 8'd255, 1'b0, 4'd4, 8'd64, 8'd32, 8'd16, 8'd8};
    tbl[1] = {4'd0, 8'd127, 1'b1, 4'd1, 8'd32, 8'd16, 8'd8, 8'd4};
    tbl[2] = {4'd1, 8'd0, 1'b1, 4'd2, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[3] = {4'd2, 8'd63, 1'b1, 4'd3, 8'd16, 8'd8, 8'd4, 8'd2};
    tbl[4] = {4'd5, 8'd200, 1'b1, 4'd6, 8'd50, 8'd25, 8'd12, 8'd6};
    repeat (2) @(negedge clk);
    check("reset", ev(0, 0, 1, 0, 0, 0, 0, 0), ALL);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle", ev(0, 0, 1, 0, 0, 0, 0, 0), SM);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = tbl[i].pat ? rnd_row() : pat_row();
      brightness = tbl[i].bri;
      fetch(i, int'(tbl[i].dly), d, 1'b0, int'(tbl[i].req));
      run_row(i, d, tbl[i].bri, 1'b1, tbl[i].on);
    end
    d = rnd_row();
    brightness = 8'd255;
    fetch(5, 0, d, 1'b0, 1);
    g = 0;
    while (hub_noe && g < 400) begin
      @(negedge clk);
      g++;
    end
    check_int("reach_display_row5", int'(hub_noe), 0);
    rst = 1'b1;
    #1;
    check("reset_mid_display", ev(0, 0, 1, 0, 0, 0, 0, 0), ALL);
    @(negedge clk);
    rst = 1'b0;
    exp_mux = '0;
    @(negedge clk);
    check("resume_row0", ev(0, 0, 1, 0, 0, 0, 1, 0), SM);
    for (int r = 0; r < 16; r++) begin
      d = rnd_row();
      dl = $urandom_range(0, 3);
      fetch(r, dl, d, 1'b0, dl + 1);
      run_row(r, d, 8'($urandom), 1'b0, '0);
    end
    d = rnd_row();
    fetch(0, 1, d, 1'b1, 2);
    enable = 1'b0;
    run_row(0, d, 8'($urandom), 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      check("idle_after_row", ev(0, 0, 1, exp_mux, 0, 0, 0, 1), SM);
      @(negedge clk);
    end
    enable = 1'b1;
    d = rnd_row();
    fetch(1, 2, d, 1'b0, 3);
    run_row(1, d, 8'd255, 1'b1, {8'd64, 8'd32, 8'd16, 8'd8});
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_ctl.md
HUB75_BCM_CTL -- requirements
Module: hub75_bcm_ctl

Interface
REQ-001 Parameters (name, default, meaning):
- COLOR_COUNT, 3: colour channels per section.
- COLOR_BITS, 4: bit planes per colour.
- COL_ADDR_BITS, 6: log2 of columns per row (C = 2**COL_ADDR_BITS).
- ROW_ADDR_BITS, 4: log2 of scan rows (R = 2**ROW_ADDR_BITS).
- SECTIONS, 2: simultaneously driven panel sections.
- BLANK_CYCLES, 4: cycles with hub_noe high before and after each latch.
- ON_UNIT, 8: display-window length of plane 0, in clk cycles.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- enable, in, 1: run the scan.
- brightness, in, 8: global dimming.
- row_in, in, SECTIONS*COLOR_COUNT*C*COLOR_BITS: row pixel data.
- row_valid, in, 1: row_in is valid for next_row.
- row_req, out, 1: row fetch request.
- next_row, out, ROW_ADDR_BITS: row being requested.
- hub_clk, out, 1: panel shift clock.
- hub_lat, out, 1: panel latch strobe.
- hub_noe, out, 1: panel output enable, active-low.
- hub_mux, out, ROW_ADDR_BITS: displayed row address.
- s_out, out, SECTIONS*COLOR_COUNT: serial data, bit index s*COLOR_COUNT+c.
- frame_done, out, 1: one-cycle end-of-frame pulse.

Function
REQ-003 Pixel (s,c,col) plane b SHALL occupy row_in bit ((s*COLOR_COUNT+c)*C+col)*COLOR_BITS+b.
REQ-004 States SHALL be IDLE, FETCH, SHIFT, BLANK_PRE, LATCH, BLANK_POST, DISPLAY.
REQ-005 IDLE: enable=1 SHALL enter FETCH next cycle; hub_noe=1 throughout IDLE.
REQ-006 FETCH: row_req=1 and next_row held stable until row_valid sampled 1. On that edge, row_in SHALL be copied into an internal buffer and the state SHALL go to SHIFT with plane b=0. row_req SHALL be 0 the following cycle.
REQ-007 row_valid SHALL be ignored when row_req=0.
REQ-008 SHIFT SHALL take 2*C cycles, columns C-1 down to 0, 2 cycles per column:
- Cycle 1: hub_clk=0, s_out = plane b of that column for every (s,c).
- Cycle 2: hub_clk=1, s_out unchanged.
REQ-009 BLANK_PRE SHALL last BLANK_CYCLES cycles with hub_noe=1 and hub_clk=0.
REQ-010 LATCH SHALL last 1 cycle with hub_lat=1 and hub_noe=1, and hub_mux SHALL update to the buffered row on that cycle.
REQ-011 BLANK_POST SHALL last BLANK_CYCLES cycles with hub_noe=1.
REQ-012 DISPLAY SHALL last W = ON_UNIT<<b cycles. hub_noe=0 only during the first N = (W*(brightness+1))>>8 of those cycles, computed at full width without truncation before the shift. brightness SHALL be sampled on entry to DISPLAY.
REQ-013 After DISPLAY:
- b < COLOR_BITS-1: b+1, then SHIFT.
- Otherwise: next_row increments (R-1 wraps to 0), then FETCH, or IDLE if enable=0.
REQ-014 frame_done SHALL pulse 1 cycle on the DISPLAY exit of plane COLOR_BITS-1 of row R-1.
REQ-015 enable deassertion mid-row SHALL NOT abort; the row completes first.
REQ-016 hub_noe SHALL be 1 whenever state is not DISPLAY. hub_lat=1 only in LATCH. hub_clk=0 outside SHIFT.

Reset
REQ-017 While rst=1, asynchronously:
- hub_clk=0, hub_lat=0, hub_noe=1, hub_mux=0, s_out=0, row_req=0, next_row=0, frame_done=0.
- State IDLE, plane 0, buffer cleared.
REQ-018 After rst falls, operation SHALL resume from IDLE, row 0, even if reset arrived mid-SHIFT or mid-DISPLAY.

Verification
REQ-019 rst asserted mid-DISPLAY of row 5 -> same cycle: hub_noe=1, s_out=0, hub_mux=0; after release and enable=1, next_row=0 and row_req=1.
REQ-020 enable=1, row_valid raised 3 cycles after row_req -> row_req high exactly 4 cycles with next_row=0 stable, then SHIFT starts.
REQ-021 Defaults, all pixels 4'b1010 in section 0 channel 0, others 0 -> s_out[0] is 0/1/0/1 in planes 0..3; s_out[5:1]=0; 64 hub_clk rising edges per plane.
REQ-022 Defaults, brightness=255 -> per row, hub_noe low 8,16,32,64 cycles and exactly 4 hub_lat pulses, each with hub_noe=1 for 4 cycles either side.
REQ-023 brightness=127 -> hub_noe low 4,8,16,32; brightness=0, plane 0 -> N=0, hub_noe stays high for the whole window.
REQ-024 Run a full frame -> hub_mux=15 during row 15 display, a single frame_done pulse, then next_row wraps to 0 and row_req reasserts.
